simd_word_sequencer: RTL and testbench

- Upstream issue stage for the 32-bit Multi_Alu in the SIMD AES datapath.
- Accepts one 128-bit vector operation (two 128-bit operands plus a 3-bit opcode) over a valid/ready handshake.
- Issues the operation to the combinational ALU one 32-bit word per cycle, captures each result_alu word, and presents the assembled 128-bit result over a second valid/ready handshake.

---
 rtl/simd_word_sequencer.sv | 125 ++++++++++++
 tb/tb_simd_word_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_word_sequencer.sv
// Word-serial issue stage for the 32-bit Multi_Alu: takes one vector op,
// walks it through the ALU a word per cycle, and returns the assembled result.
module simd_word_sequencer #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_op,
  input  logic [NUM_WORDS*WORD_W-1:0] in_a,
  input  logic [NUM_WORDS*WORD_W-1:0] in_b,
  output logic [WORD_W-1:0]           alu_a,
  output logic [WORD_W-1:0]           alu_b,
  output logic [2:0]                  alu_select,
  input  logic [WORD_W-1:0]           alu_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_result,
  output logic                        busy
);

  localparam int VEC_W = NUM_WORDS * WORD_W;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [VEC_W-1:0]   r_a;
  logic [VEC_W-1:0]   r_b;
  logic [2:0]         r_op;
  logic [IDX_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_res [NUM_WORDS];
  logic               w_issue;
  logic               w_accept;
  logic [WORD_W-1:0]  w_a_word;
  logic [WORD_W-1:0]  w_b_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_issue   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy    = 1'b1;
        w_issue = 1'b1;
        if (r_idx == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_op  <= in_op;
      r_idx <= '0;
    end else if (w_issue && r_idx != LAST) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Reset also wipes partially captured words of an aborted op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WORDS; k++) r_res[k] <= '0;
    end else if (w_issue) begin
      r_res[r_idx] <= alu_result;
    end
  end

  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_word = r_a[k*WORD_W +: WORD_W];
        w_b_word = r_b[k*WORD_W +: WORD_W];
      end
    end
  end

  // ALU inputs come only from registers, never from the handshake inputs.
  assign alu_a      = w_issue ? w_a_word : '0;
  assign alu_b      = w_issue ? w_b_word : '0;
  assign alu_select = w_issue ? r_op : 3'b000;

  always_comb begin
    out_result = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      out_result[k*WORD_W +: WORD_W] = r_res[k];
  end

endmodule

// File: tb/tb_simd_word_sequencer.sv
// Bench for simd_word_sequencer: stand-in ALU, cycle model of the vector
// op timeline, and directed vectors with literal expectations.
module tb_simd_word_sequencer;

  localparam int NW = 4;
  localparam int WW = 32;
  localparam int VW = NW * WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'b000;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;
  logic [WW-1:0] alu_a;
  logic [WW-1:0] alu_b;
  logic [2:0]    alu_select;
  logic [WW-1:0] alu_result;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_result;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  simd_word_sequencer #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  function automatic logic [7:0] gmul(
    input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    logic [7:0] yy;
    p  = 8'h00;
    xx = x;
    yy = y;
    for (int i = 0; i < 8; i++) begin
      if (yy[0]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      yy = yy >> 1;
    end
    return p;
  endfunction

  function automatic logic [WW-1:0] alu_fn(
    input logic [2:0] s, input logic [WW-1:0] a,
    input logic [WW-1:0] b);
    logic [WW-1:0] r;
    case (s)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a * b;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: begin
        for (int i = 0; i < 4; i++)
          r[i*8 +: 8] = gmul(a[i*8 +: 8], b[7:0]);
      end
      3'b110: r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  assign alu_result = alu_fn(alu_select, alu_a, alu_b);

  task automatic check(input string nm, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model: an op is a timeline of NW issue cycles then a wait for out_ready.
  logic          m_active;
  int            m_n;
  logic [VW-1:0] m_a, m_b, m_exp, m_last;
  logic [2:0]    m_op;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_n      <= 0;
      m_a      <= '0;
      m_b      <= '0;
      m_op     <= 3'b000;
      m_exp    <= '0;
      m_last   <= '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_n      <= 0;
        m_a      <= in_a;
        m_b      <= in_b;
        m_op     <= in_op;
        for (int k = 0; k < NW; k++)
          m_exp[k*WW +: WW] <= alu_fn(in_op, in_a[k*WW +: WW],
                                      in_b[k*WW +: WW]);
      end
    end else if (m_n < NW) begin
      m_n <= m_n + 1;
    end else if (out_ready) begin
      m_active <= 1'b0;
      m_last   <= m_exp;
    end
  end

  always @(negedge clk) begin
    logic          iss;
    logic [VW-1:0] er;
    logic [WW-1:0] ea, eb;
    iss = m_active && (m_n < NW);
    ea  = iss ? m_a[m_n*WW +: WW] : '0;
    eb  = iss ? m_b[m_n*WW +: WW] : '0;
    for (int j = 0; j < NW; j++)
      er[j*WW +: WW] = (m_active && j < m_n) ?
                       m_exp[j*WW +: WW] : m_last[j*WW +: WW];
    check("in_ready", VW'(in_ready), VW'(!m_active));
    check("busy", VW'(busy), VW'(m_active));
    check("out_valid", VW'(out_valid), VW'(m_active && m_n == NW));
    check("alu_a", VW'(alu_a), VW'(ea));
    check("alu_b", VW'(alu_b), VW'(eb));
    check("alu_select", VW'(alu_select), VW'(iss ? m_op : 3'b000));
    check("out_result", out_result, er);
  end

  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [2:0] op);
    int t;
    t = 0;
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    while (!in_ready && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 40) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("done_timeout", 1, 0);
  endtask

  function automatic logic [VW-1:0] rep(input logic [WW-1:0] w);
    return {NW{w}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] held;
    #12 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_in_ready", VW'(in_ready), 1);
    check("rst_out_valid", VW'(out_valid), 0);
    check("rst_busy", VW'(busy), 0);
    check("rst_result", out_result, 0);

    // add, with literal word-by-word issue checks
    send({32'd4, 32'd3, 32'd2, 32'd1}, rep(32'd1), 3'b000);
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      check("add_alu_a", VW'(alu_a), VW'(k + 1));
      check("add_sel", VW'(alu_select), 0);
    end
    @(negedge clk);
    check("add_valid", VW'(out_valid), 1);
    check("add_result", out_result,
          {32'h5, 32'h4, 32'h3, 32'h2});

    send(rep(32'd5), rep(32'd3), 3'b001);
    wait_valid();
    check("sub_result", out_result, rep(32'd2));
    send(rep(32'd2), rep(32'd3), 3'b010);
    wait_valid();
    check("mul_result", out_result, rep(32'd6));

    send({96'h0, 32'h632FAFA2}, {96'h0, 32'h1}, 3'b101);
    @(negedge clk);
    check("gf_alu_a", VW'(alu_a), VW'(32'h632FAFA2));
    check("gf_sel", VW'(alu_select), VW'(3'b101));
    wait_valid();
    check("gf_word0", VW'(out_result[31:0]), VW'(32'h632FAFA2));

    // backpressure with a competing in_valid
    @(negedge clk); #1;
    out_ready = 1'b0;
    send(rep(32'h10), rep(32'h7), 3'b110);
    wait_valid();
    held = out_result;
    #1;
    in_valid = 1'b1;
    in_a = rep(32'hDEAD0000);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_valid", VW'(out_valid), 1);
      check("bp_in_ready", VW'(in_ready), 0);
      check("bp_stable", out_result, held);
    end
    check("bp_value", held, rep(32'h17));
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", VW'(out_valid), 0);
    check("bp_release_ready", VW'(in_ready), 1);

    // operands change after accept
    send(rep(32'h100), rep(32'h23), 3'b000);
    in_a = {NW{32'hFFFFFFFF}};
    in_op = 3'b111;
    wait_valid();
    check("capture_result", out_result, rep(32'h123));

    // asynchronous reset while word 2 is on the ALU
    send({32'h44, 32'h33, 32'h22, 32'h11}, rep(32'h1), 3'b000);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", VW'(out_valid), 0);
    check("abort_result", out_result, 0);
    check("abort_in_ready", VW'(in_ready), 1);
    check("abort_alu_a", VW'(alu_a), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    send({32'h8, 32'h7, 32'h6, 32'h5}, rep(32'h2), 3'b000);
    wait_valid();
    check("post_abort_add", out_result,
          {32'hA, 32'h9, 32'h8, 32'h7});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
